// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared widths, mux-select codes and shadow pipeline-stage field types
// for the EX-stage forwarding / load-use hazard controller.
package cpu_fwd_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int SEL_W      = 2;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [SEL_W-1:0]      fwd_sel_t;

  localparam fwd_sel_t  FWD_SEL_REGFILE = 2'd0;
  localparam fwd_sel_t  FWD_SEL_EXMEM   = 2'd1;
  localparam fwd_sel_t  FWD_SEL_MEMWB   = 2'd2;
  localparam reg_addr_t ZERO_REG        = '0;

  typedef struct packed {
    reg_addr_t rs1;
    reg_addr_t rs2;
    logic      use1;
    logic      use2;
    reg_addr_t rd;
    logic      rw;
    logic      mr;
  } idex_t;

  // The load flag is only consulted while the load sits in ID/EX, so the
  // later stages carry just the writeback destination.
  typedef struct packed {
    reg_addr_t rd;
    logic      rw;
  } exmem_t;

  typedef struct packed {
    reg_addr_t rd;
    logic      rw;
  } memwb_t;
endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage request fields in, operand-mux selects / stall status out.
interface fwd_hazard_ctrl_if
  import cpu_fwd_pkg::*;
#(
  parameter int CNT_W = 32
);
  reg_addr_t          id_rs1;
  reg_addr_t          id_rs2;
  logic               id_use_rs1;
  logic               id_use_rs2;
  reg_addr_t          id_rd;
  logic               id_reg_write;
  logic               id_mem_read;
  logic               flush;
  fwd_sel_t           alu_fwd_a;
  fwd_sel_t           alu_fwd_b;
  logic               stall;
  logic [CNT_W-1:0]   stall_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write,
           id_mem_read, flush,
    input  alu_fwd_a, alu_fwd_b, stall, stall_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write,
           id_mem_read, flush,
    output alu_fwd_a, alu_fwd_b, stall, stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_ctrl_cmp.sv
// Priority compare for one ALU operand: youngest matching producer wins.
module fwd_sel_compare
  import cpu_fwd_pkg::*;
(
  input  reg_addr_t rs,
  input  logic      use_rs,
  input  reg_addr_t exmem_rd,
  input  logic      exmem_rw,
  input  reg_addr_t memwb_rd,
  input  logic      memwb_rw,
  output fwd_sel_t  sel
);
  logic live;

  always_comb begin
    sel  = FWD_SEL_REGFILE;
    live = use_rs && (rs != ZERO_REG);
    if (live && exmem_rw && (exmem_rd == rs))
      sel = FWD_SEL_EXMEM;
    else if (live && memwb_rw && (memwb_rd == rs))
      sel = FWD_SEL_MEMWB;
  end
endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Shadow ID/EX, EX/MEM, MEM/WB control fields; drives EX operand-mux
// selects and the one-cycle load-use stall with a saturating stall count.
module fwd_hazard_ctrl
  import cpu_fwd_pkg::*;
#(
  parameter int CNT_W = 32
)(
  input  logic                clk,
  input  logic                rst,
  fwd_hazard_ctrl_if.slave    bus
);
  localparam int NUM_OPS = 2;

  idex_t            idex_q,  idex_d;
  exmem_t           exmem_q, exmem_d;
  memwb_t           memwb_q, memwb_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             stall;

  logic [NUM_OPS-1:0][REG_ADDR_W-1:0] op_rs;
  logic [NUM_OPS-1:0]                 op_use;
  logic [NUM_OPS-1:0][SEL_W-1:0]      op_sel;

  always_comb begin
    stall = idex_q.mr && (idex_q.rd != ZERO_REG) &&
            ((bus.id_use_rs1 && (bus.id_rs1 == idex_q.rd)) ||
             (bus.id_use_rs2 && (bus.id_rs2 == idex_q.rd)));

    idex_d = '{rs1: bus.id_rs1, rs2: bus.id_rs2, use1: bus.id_use_rs1,
               use2: bus.id_use_rs2, rd: bus.id_rd, rw: bus.id_reg_write,
               mr: bus.id_mem_read};
    // Stall and flush both insert the same all-zero bubble.
    if (stall || bus.flush) idex_d = '0;

    exmem_d = '{rd: idex_q.rd, rw: idex_q.rw};
    memwb_d = '{rd: exmem_q.rd, rw: exmem_q.rw};

    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
      cnt_q   <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign op_rs  = {idex_q.rs2, idex_q.rs1};
  assign op_use = {idex_q.use2, idex_q.use1};

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
    fwd_sel_compare u_cmp (
      .rs       (op_rs[i]),
      .use_rs   (op_use[i]),
      .exmem_rd (exmem_q.rd),
      .exmem_rw (exmem_q.rw),
      .memwb_rd (memwb_q.rd),
      .memwb_rw (memwb_q.rw),
      .sel      (op_sel[i])
    );
  end

  assign bus.alu_fwd_a = op_sel[0];
  assign bus.alu_fwd_b = op_sel[1];
  assign bus.stall     = stall;
  assign bus.stall_cnt = cnt_q;
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed-vector bench for fwd_hazard_ctrl; expected values hand-derived.
module tb_fwd_hazard_ctrl;
  import cpu_fwd_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  fwd_hazard_ctrl_if bus ();

  fwd_hazard_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Drive one ID-stage instruction (inputs only; advance with tick()).
  task automatic issue(input int rs1, input int rs2, input bit u1, input bit u2,
                       input int rd, input bit rw, input bit mr, input bit fl);
    bus.id_rs1       = reg_addr_t'(rs1);
    bus.id_rs2       = reg_addr_t'(rs2);
    bus.id_use_rs1   = u1;
    bus.id_use_rs2   = u2;
    bus.id_rd        = reg_addr_t'(rd);
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
    bus.flush        = fl;
  endtask

  task automatic nop();
    issue(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    nop();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (bus.alu_fwd_a !== 2'd0) begin errors++; $display("FAIL reset_fwd_a got %0d exp 0", bus.alu_fwd_a); end
    checks++; if (bus.alu_fwd_b !== 2'd0) begin errors++; $display("FAIL reset_fwd_b got %0d exp 0", bus.alu_fwd_b); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0d exp 0", bus.stall); end
    checks++; if (bus.stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", bus.stall_cnt); end
  endtask

  task automatic test_back_to_back();
    drain();
    issue(1, 2, 1, 1, 5, 1, 0, 0);      // add x5
    tick();
    issue(5, 6, 1, 1, 11, 1, 0, 0);     // sub x11, x5, x6
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL b2b_stall got %0d exp 0", bus.stall); end
    tick();
    checks++; if (bus.alu_fwd_a !== 2'd1) begin errors++; $display("FAIL b2b_fwd_a got %0d exp 1", bus.alu_fwd_a); end
    checks++; if (bus.alu_fwd_b !== 2'd0) begin errors++; $display("FAIL b2b_fwd_b got %0d exp 0", bus.alu_fwd_b); end
  endtask

  task automatic test_distance2();
    drain();
    issue(1, 2, 1, 1, 7, 1, 0, 0);      // write x7
    tick();
    issue(1, 2, 1, 1, 10, 1, 0, 0);     // independent
    tick();
    issue(1, 7, 1, 1, 12, 1, 0, 0);     // reads rs2=x7
    tick();
    checks++; if (bus.alu_fwd_b !== 2'd2) begin errors++; $display("FAIL dist2_fwd_b got %0d exp 2", bus.alu_fwd_b); end
    checks++; if (bus.alu_fwd_a !== 2'd0) begin errors++; $display("FAIL dist2_fwd_a got %0d exp 0", bus.alu_fwd_a); end
    drain();
    issue(1, 2, 1, 1, 7, 1, 0, 0);
    tick();
    issue(1, 2, 1, 1, 7, 1, 0, 0);
    tick();
    issue(1, 7, 1, 1, 12, 1, 0, 0);
    tick();
    checks++; if (bus.alu_fwd_b !== 2'd1) begin errors++; $display("FAIL prio_fwd_b got %0d exp 1", bus.alu_fwd_b); end
  endtask

  task automatic test_load_use();
    drain();
    issue(1, 0, 1, 0, 3, 1, 1, 0);      // lw x3
    tick();
    issue(3, 2, 1, 1, 8, 1, 0, 0);      // add x8, x3, x2
    #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %0d exp 1", bus.stall); end
    checks++; if (bus.stall_cnt !== 32'd0) begin errors++; $display("FAIL lu_cnt0 got %0d exp 0", bus.stall_cnt); end
    tick();                              // add held in ID, bubble into EX
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL lu_stall_once got %0d exp 0", bus.stall); end
    checks++; if (bus.stall_cnt !== 32'd1) begin errors++; $display("FAIL lu_cnt1 got %0d exp 1", bus.stall_cnt); end
    checks++; if (bus.alu_fwd_a !== 2'd0) begin errors++; $display("FAIL lu_bubble_fwd_a got %0d exp 0", bus.alu_fwd_a); end
    tick();
    checks++; if (bus.alu_fwd_a !== 2'd2) begin errors++; $display("FAIL lu_fwd_a got %0d exp 2", bus.alu_fwd_a); end
    checks++; if (bus.stall_cnt !== 32'd1) begin errors++; $display("FAIL lu_cnt_hold got %0d exp 1", bus.stall_cnt); end
  endtask

  task automatic test_zero_unused();
    drain();
    issue(1, 2, 1, 1, 0, 1, 0, 0);      // writer to x0
    tick();
    issue(0, 2, 1, 1, 9, 1, 0, 0);      // reads x0
    tick();
    checks++; if (bus.alu_fwd_a !== 2'd0) begin errors++; $display("FAIL x0_fwd_a got %0d exp 0", bus.alu_fwd_a); end
    drain();
    issue(1, 0, 1, 0, 4, 1, 1, 0);      // lw x4
    tick();
    issue(2, 4, 1, 0, 9, 1, 0, 0);      // rs2=x4 but unused
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL unused_stall got %0d exp 0", bus.stall); end
    tick();
    checks++; if (bus.alu_fwd_b !== 2'd0) begin errors++; $display("FAIL unused_fwd_b got %0d exp 0", bus.alu_fwd_b); end
    checks++; if (bus.stall_cnt !== 32'd1) begin errors++; $display("FAIL unused_cnt got %0d exp 1", bus.stall_cnt); end
  endtask

  task automatic test_flush_stall();
    drain();
    issue(1, 0, 1, 0, 9, 1, 1, 0);      // lw x9
    tick();
    issue(9, 0, 1, 0, 13, 1, 0, 1);     // reader of x9, squashed
    #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL fl_stall got %0d exp 1", bus.stall); end
    tick();
    checks++; if (bus.stall_cnt !== 32'd2) begin errors++; $display("FAIL fl_cnt got %0d exp 2", bus.stall_cnt); end
    checks++; if (bus.alu_fwd_a !== 2'd0) begin errors++; $display("FAIL fl_bubble_fwd_a got %0d exp 0", bus.alu_fwd_a); end
    issue(9, 0, 1, 0, 14, 1, 0, 0);     // fresh reader of x9
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL fl_stall_after got %0d exp 0", bus.stall); end
    tick();                              // EX/MEM=bubble, MEM/WB=lw x9
    checks++; if (bus.alu_fwd_a !== 2'd2) begin errors++; $display("FAIL fl_fwd_a got %0d exp 2", bus.alu_fwd_a); end
    checks++; if (bus.stall_cnt !== 32'd2) begin errors++; $display("FAIL fl_cnt_hold got %0d exp 2", bus.stall_cnt); end
  endtask

  task automatic test_reset_mid();
    drain();
    issue(1, 2, 1, 1, 5, 1, 0, 0);      // writer x5
    tick();
    nop();
    tick();                              // x5 writer now in EX/MEM
    issue(5, 0, 1, 0, 6, 1, 1, 0);      // discarded by reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.alu_fwd_a !== 2'd0) begin errors++; $display("FAIL rst_fwd_a got %0d exp 0", bus.alu_fwd_a); end
    checks++; if (bus.alu_fwd_b !== 2'd0) begin errors++; $display("FAIL rst_fwd_b got %0d exp 0", bus.alu_fwd_b); end
    checks++; if (bus.stall_cnt !== 32'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", bus.stall_cnt); end
    issue(5, 0, 1, 0, 6, 1, 0, 0);
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %0d exp 0", bus.stall); end
    tick();
    checks++; if (bus.alu_fwd_a !== 2'd0) begin errors++; $display("FAIL rst_reader_fwd_a got %0d exp 0", bus.alu_fwd_a); end
  endtask

  initial begin
    nop();
    test_reset();
    test_back_to_back();
    test_distance2();
    test_load_use();
    test_zero_unused();
    test_flush_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
